// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC core: opcode encodings, writeback
// source codes and the sequencer state encoding.
package risc_pkg;

    localparam int unsigned PC_W     = 8;
    localparam int unsigned OPC_BITS = 3;

    localparam logic [OPC_BITS-1:0] OPC_ALU  = 3'b000;
    localparam logic [OPC_BITS-1:0] OPC_LDI  = 3'b001;
    localparam logic [OPC_BITS-1:0] OPC_LD   = 3'b010;
    localparam logic [OPC_BITS-1:0] OPC_ST   = 3'b011;
    localparam logic [OPC_BITS-1:0] OPC_BEQZ = 3'b100;
    localparam logic [OPC_BITS-1:0] OPC_JMP  = 3'b101;
    localparam logic [OPC_BITS-1:0] OPC_NOP  = 3'b110;
    localparam logic [OPC_BITS-1:0] OPC_HALT = 3'b111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

endpackage

// File: rtl/pc_seq_decode.sv
// Combinational opcode-to-class decoder used by the pc_sequencer FSM.
module pc_seq_decode
    import risc_pkg::*;
#(
    parameter int unsigned OPC_W = 3
) (
    input  logic [OPC_W-1:0] opcode,
    output logic             is_mem,
    output logic             is_store,
    output logic             is_branch,
    output logic             is_jump,
    output logic             is_nop,
    output logic             is_halt,
    output logic             writes_reg,
    output logic [1:0]       wb_sel
);

    always_comb begin
        is_mem     = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_nop     = 1'b0;
        is_halt    = 1'b0;
        writes_reg = 1'b0;
        wb_sel     = WB_ALU;
        case (opcode)
            OPC_ALU: begin
                writes_reg = 1'b1;
                wb_sel     = WB_ALU;
            end
            OPC_LDI: begin
                writes_reg = 1'b1;
                wb_sel     = WB_IMM;
            end
            OPC_LD: begin
                is_mem     = 1'b1;
                writes_reg = 1'b1;
                wb_sel     = WB_MEM;
            end
            OPC_ST: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OPC_BEQZ: is_branch = 1'b1;
            OPC_JMP:  is_jump   = 1'b1;
            OPC_NOP:  is_nop    = 1'b1;
            default:  is_halt   = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit RISC core.
// Optional retired-instruction counter: define PC_SEQUENCER_RETIRE_CNT_EN.
module pc_sequencer
    import risc_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned OPC_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero_flag,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             loadir,
    output logic             loadpc,
    output logic             pc_jump,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
`ifdef PC_SEQUENCER_RETIRE_CNT_EN
    output logic [15:0]      retire_cnt,
`endif
    output logic             halted
);

    if (ADDR_W != PC_W) begin : g_addr_w_check
        $error("pc_sequencer: ADDR_W must match the program counter width");
    end
    if (OPC_W != OPC_BITS) begin : g_opc_w_check
        $error("pc_sequencer: OPC_W must match the opcode encoding width");
    end

    state_t     state_q, state_d;
    logic       is_mem, is_store, is_branch, is_jump, is_nop, is_halt, writes_reg;
    logic [1:0] dec_wb_sel;

    pc_seq_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode     (opcode),
        .is_mem     (is_mem),
        .is_store   (is_store),
        .is_branch  (is_branch),
        .is_jump    (is_jump),
        .is_nop     (is_nop),
        .is_halt    (is_halt),
        .writes_reg (writes_reg),
        .wb_sel     (dec_wb_sel)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        loadir   = 1'b0;
        loadpc   = 1'b0;
        pc_jump  = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = WB_ALU;
        halted   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    loadir  = 1'b1;
                    loadpc  = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_halt)     state_d = ST_HALT;
                else if (is_nop) state_d = ST_FETCH;
                else             state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_mem) begin
                    state_d = ST_MEM;
                end else begin
                    reg_we  = writes_reg;
                    wb_sel  = dec_wb_sel;
                    pc_jump = is_jump | (is_branch & zero_flag);
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                if (mem_ack) state_d = is_store ? ST_FETCH : ST_WB;
            end
            ST_WB: begin
                reg_we  = 1'b1;
                wb_sel  = WB_MEM;
                state_d = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_FETCH;
        endcase

        // Reset is asynchronous, so the Mealy outputs must be silenced
        // combinationally rather than waiting for the state flop.
        if (!reset) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 1'b0;
            loadir   = 1'b0;
            loadpc   = 1'b0;
            pc_jump  = 1'b0;
            reg_we   = 1'b0;
            wb_sel   = WB_ALU;
            halted   = 1'b0;
        end
    end

`ifdef PC_SEQUENCER_RETIRE_CNT_EN
    logic [15:0] retire_cnt_q, retire_cnt_d;
    logic        retire;

    // An instruction retires on the last cycle before FETCH, or on HALT entry.
    always_comb begin
        retire = (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) &&
                 (state_d inside {ST_FETCH, ST_HALT});
        retire_cnt_d = retire ? retire_cnt_q + 16'd1 : retire_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retire_cnt_q <= '0;
        else        retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Output vector order: {mem_req, mem_we, addr_sel, loadir, loadpc, pc_jump, reg_we, wb_sel[1:0], halted}.
module tb_pc_sequencer;
    import risc_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] opcode = OPC_NOP;
    logic       zero_flag = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, addr_sel, loadir, loadpc, pc_jump, reg_we, halted;
    logic [1:0] wb_sel;
`ifdef PC_SEQUENCER_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif
    logic [9:0] outs;

    int unsigned total = 0;
    int unsigned passed = 0;

    localparam logic [9:0] O_IDLE   = 10'b0000000000;
    localparam logic [9:0] O_FWAIT  = 10'b1000000000;
    localparam logic [9:0] O_FACK   = 10'b1001100000;
    localparam logic [9:0] O_ALU    = 10'b0000001000;
    localparam logic [9:0] O_LDI    = 10'b0000001100;
    localparam logic [9:0] O_JUMP   = 10'b0000010000;
    localparam logic [9:0] O_MEM_LD = 10'b1010000000;
    localparam logic [9:0] O_MEM_ST = 10'b1110000000;
    localparam logic [9:0] O_WB     = 10'b0000001010;
    localparam logic [9:0] O_HALT   = 10'b0000000001;

    always #5 clk = ~clk;

    assign outs = {mem_req, mem_we, addr_sel, loadir, loadpc, pc_jump, reg_we, wb_sel, halted};

    pc_sequencer #(.ADDR_W(8), .OPC_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .zero_flag (zero_flag),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .loadir    (loadir),
        .loadpc    (loadpc),
        .pc_jump   (pc_jump),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
`ifdef PC_SEQUENCER_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .halted    (halted)
    );

    // Row = {mem_ack, zero_flag, opcode[2:0], expected outs[9:0]}
    task automatic test_reset();
        reset = 1'b0;
        mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (outs !== O_IDLE) $display("FAIL reset_outs: got %b expected %b", outs, O_IDLE);
        else passed++;
`ifdef PC_SEQUENCER_RETIRE_CNT_EN
        total++;
        if (retire_cnt !== 16'd0) $display("FAIL reset_retire: got %0d expected 0", retire_cnt);
        else passed++;
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if (outs !== O_FWAIT) $display("FAIL first_fetch: got %b expected %b", outs, O_FWAIT);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch_wait();
        logic [14:0] r [5];
        r = '{{2'b00, OPC_NOP, O_FWAIT}, {2'b00, OPC_NOP, O_FWAIT}, {2'b00, OPC_NOP, O_FWAIT},
              {2'b10, OPC_NOP, O_FACK},  {2'b00, OPC_NOP, O_IDLE}};
        for (int i = 0; i < 5; i++) begin
            {mem_ack, zero_flag, opcode} = r[i][14:10];
            @(negedge clk);
            total++;
            if (outs !== r[i][9:0]) $display("FAIL fetch_wait[%0d]: got %b expected %b", i, outs, r[i][9:0]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ldi_alu_nop();
        logic [14:0] r [8];
        r = '{{2'b10, OPC_LDI, O_FACK}, {2'b00, OPC_LDI, O_IDLE}, {2'b00, OPC_LDI, O_LDI},
              {2'b10, OPC_ALU, O_FACK}, {2'b00, OPC_ALU, O_IDLE}, {2'b00, OPC_ALU, O_ALU},
              {2'b10, OPC_NOP, O_FACK}, {2'b00, OPC_NOP, O_IDLE}};
        for (int i = 0; i < 8; i++) begin
            {mem_ack, zero_flag, opcode} = r[i][14:10];
            @(negedge clk);
            total++;
            if (outs !== r[i][9:0]) $display("FAIL ldi_alu_nop[%0d]: got %b expected %b", i, outs, r[i][9:0]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        logic [14:0] r [7];
        r = '{{2'b10, OPC_LD, O_FACK},   {2'b00, OPC_LD, O_IDLE},   {2'b00, OPC_LD, O_IDLE},
              {2'b00, OPC_LD, O_MEM_LD}, {2'b00, OPC_LD, O_MEM_LD}, {2'b10, OPC_LD, O_MEM_LD},
              {2'b00, OPC_LD, O_WB}};
        for (int i = 0; i < 7; i++) begin
            {mem_ack, zero_flag, opcode} = r[i][14:10];
            @(negedge clk);
            total++;
            if (outs !== r[i][9:0]) $display("FAIL load_wait[%0d]: got %b expected %b", i, outs, r[i][9:0]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump_store();
        logic [14:0] r [14];
        r = '{{2'b11, OPC_BEQZ, O_FACK}, {2'b01, OPC_BEQZ, O_IDLE}, {2'b01, OPC_BEQZ, O_JUMP},
              {2'b10, OPC_BEQZ, O_FACK}, {2'b00, OPC_BEQZ, O_IDLE}, {2'b00, OPC_BEQZ, O_IDLE},
              {2'b10, OPC_JMP,  O_FACK}, {2'b00, OPC_JMP,  O_IDLE}, {2'b00, OPC_JMP,  O_JUMP},
              {2'b10, OPC_ST,   O_FACK}, {2'b00, OPC_ST,   O_IDLE}, {2'b00, OPC_ST,   O_IDLE},
              {2'b10, OPC_ST,   O_MEM_ST}, {2'b00, OPC_ST, O_FWAIT}};
        for (int i = 0; i < 14; i++) begin
            {mem_ack, zero_flag, opcode} = r[i][14:10];
            @(negedge clk);
            total++;
            if (outs !== r[i][9:0]) $display("FAIL branch_jump_store[%0d]: got %b expected %b", i, outs, r[i][9:0]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_store();
        logic [14:0] r [4];
        r = '{{2'b00, OPC_ST, O_FWAIT}, {2'b10, OPC_ST, O_FACK}, {2'b00, OPC_ST, O_IDLE},
              {2'b00, OPC_ST, O_IDLE}};
        // Previous task leaves the FSM in FETCH.
        for (int i = 1; i < 4; i++) begin
            {mem_ack, zero_flag, opcode} = r[i][14:10];
            @(negedge clk);
            total++;
            if (outs !== r[i][9:0]) $display("FAIL reset_st_pre[%0d]: got %b expected %b", i, outs, r[i][9:0]);
            else passed++;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if (outs !== O_MEM_ST) $display("FAIL reset_st_mem: got %b expected %b", outs, O_MEM_ST);
        else passed++;
        #2 reset = 1'b0;
        #1;
        total++;
        if (outs !== O_IDLE) $display("FAIL reset_st_async: got %b expected %b", outs, O_IDLE);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (outs !== r[0][9:0]) $display("FAIL reset_st_refetch: got %b expected %b", outs, r[0][9:0]);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_halt();
        logic [14:0] r [18];
        reset = 1'b0;
        #2 reset = 1'b1;
        r = '{{2'b10, OPC_LDI, O_FACK}, {2'b00, OPC_LDI, O_IDLE}, {2'b00, OPC_LDI, O_LDI},
              {2'b10, OPC_ALU, O_FACK}, {2'b00, OPC_ALU, O_IDLE}, {2'b00, OPC_ALU, O_ALU},
              {2'b10, OPC_HALT, O_FACK}, {2'b00, OPC_HALT, O_IDLE},
              {2'b11, OPC_HALT, O_HALT}, {2'b11, OPC_HALT, O_HALT}, {2'b11, OPC_JMP, O_HALT},
              {2'b11, OPC_ST,   O_HALT}, {2'b11, OPC_HALT, O_HALT}, {2'b10, OPC_LDI, O_HALT},
              {2'b01, OPC_HALT, O_HALT}, {2'b11, OPC_HALT, O_HALT}, {2'b11, OPC_ALU, O_HALT},
              {2'b11, OPC_HALT, O_HALT}};
        for (int i = 0; i < 18; i++) begin
            {mem_ack, zero_flag, opcode} = r[i][14:10];
            @(negedge clk);
            total++;
            if (outs !== r[i][9:0]) $display("FAIL halt[%0d]: got %b expected %b", i, outs, r[i][9:0]);
            else passed++;
            @(posedge clk); #1;
        end
`ifdef PC_SEQUENCER_RETIRE_CNT_EN
        total++;
        if (retire_cnt !== 16'd3) $display("FAIL retire_cnt: got %0d expected 3", retire_cnt);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_fetch_wait();
        test_ldi_alu_nop();
        test_load_wait();
        test_branch_jump_store();
        test_reset_mid_store();
        test_halt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
